ring_cal_ctrl: RTL and testbench

Calibration and tracking controller for the ADPLL ring oscillator. It gates the ring enable and drives the ring's digital tuning code. It measures ring activity over fixed windows of reference-clock cycles and runs a successive-approximation search toward a target count. It then holds lock with ±1 tracking. It sits between the reference `Clk` domain and the ring/one-shot datapath and replaces the static `volt_0`/`volt_1` enable tie-offs.

---
 rtl/ring_cal_ctrl_if.sv | 29 ++
 rtl/ring_cal_ctrl.sv | 151 +++++++++++++++
 tb/tb_ring_cal_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/ring_cal_ctrl_if.sv
// Control/status bundle between the ADPLL sequencer and ring_cal_ctrl.
//   master: drives start/stop/target and the synchronised ring_tick
//   slave : the calibration controller (ring_en, code, meas, status)
interface ring_cal_ctrl_if #(
  parameter int CODE_W = 6,
  parameter int CNT_W  = 12
);
  logic              start;
  logic              stop;
  logic [CNT_W-1:0]  target;
  logic              ring_tick;
  logic              ring_en;
  logic [CODE_W-1:0] code;
  logic [CNT_W-1:0]  meas;
  logic              meas_valid;
  logic              busy;
  logic              locked;
  logic              err;

  modport master (
    output start, stop, target, ring_tick,
    input  ring_en, code, meas, meas_valid, busy, locked, err
  );

  modport slave (
    input  start, stop, target, ring_tick,
    output ring_en, code, meas, meas_valid, busy, locked, err
  );
endinterface

// File: rtl/ring_cal_ctrl.sv
// Ring oscillator calibration/tracking controller.
// Counts ring_tick over WIN-cycle windows (after SETTLE dead cycles), runs a
// SAR search on the tuning code toward target, then tracks with +/-1 steps
// and reports lock after LOCK_N consecutive in-tolerance windows.
// Ports:
//   Clk, Rst_n : sole clock, async active-low reset
//   bus (slave): start/stop pulses, target, ring_tick in;
//                ring_en, code, meas, meas_valid, busy, locked, err out
module ring_cal_ctrl #(
  parameter int CODE_W   = 6,
  parameter int CNT_W    = 12,
  parameter int WIN      = 256,
  parameter int SETTLE   = 8,
  parameter int LOCK_TOL = 2,
  parameter int LOCK_N   = 4
) (
  input  logic           Clk,
  input  logic           Rst_n,
  ring_cal_ctrl_if.slave bus
);
  localparam int CYC_W = $clog2(WIN + SETTLE + 1);
  localparam int IDX_W = (CODE_W > 1) ? $clog2(CODE_W) : 1;
  localparam int LC_W  = $clog2(LOCK_N + 1);
  localparam logic [CYC_W-1:0] SET_LAST = CYC_W'(SETTLE - 1);
  localparam logic [CYC_W-1:0] WIN_LAST = CYC_W'(WIN - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_MEAS, S_UPD} state_t;

  state_t            r_state, w_next;
  logic [CYC_W-1:0]  r_cyc;
  logic [CNT_W-1:0]  r_cnt, r_tgt, r_meas;
  logic [CODE_W-1:0] r_code, w_sar_code;
  logic [IDX_W-1:0]  r_idx;
  logic [LC_W-1:0]   r_lcnt;
  logic              r_track, r_mv, r_locked, r_err;
  logic              w_accept, w_win_done;
  logic [CNT_W-1:0]  w_cnt_fin;
  logic signed [CNT_W+1:0] w_m, w_hi, w_lo;
  logic              w_over, w_under;

  // FSM state register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // FSM next state; stop overrides everything, including start
  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_win_done = 1'b0;
    if (bus.stop) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (bus.start) begin w_next = S_SETTLE; w_accept = 1'b1; end
        S_SETTLE: if (r_cyc == SET_LAST) w_next = S_MEAS;
        S_MEAS:   if (r_cyc == WIN_LAST) begin w_next = S_UPD; w_win_done = 1'b1; end
        S_UPD:    w_next = S_SETTLE;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  // Window count including this cycle's tick, so the last MEASURE tick lands
  // in meas; results are registered on the edge entering UPDATE.
  always_comb begin
    w_cnt_fin = r_cnt;
    if (bus.ring_tick && (r_cnt != '1)) w_cnt_fin = r_cnt + 1'b1;
  end

  // Signed compares with two guard bits so target+/-TOL never wraps
  assign w_m     = $signed({2'b00, w_cnt_fin});
  assign w_hi    = $signed({2'b00, r_tgt}) + $signed((CNT_W+2)'(LOCK_TOL));
  assign w_lo    = $signed({2'b00, r_tgt}) - $signed((CNT_W+2)'(LOCK_TOL));
  assign w_over  = (w_m > w_hi);
  assign w_under = (w_m < w_lo);

  // SAR step: drop the trial bit if too fast, then try the next lower bit
  always_comb begin
    w_sar_code = r_code;
    if (w_cnt_fin > r_tgt) w_sar_code[r_idx] = 1'b0;
    if (r_idx != '0)       w_sar_code[r_idx - 1'b1] = 1'b1;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_cyc    <= '0;
      r_cnt    <= '0;
      r_tgt    <= '0;
      r_meas   <= '0;
      r_code   <= '0;
      r_idx    <= '0;
      r_lcnt   <= '0;
      r_track  <= 1'b0;
      r_mv     <= 1'b0;
      r_locked <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_mv <= 1'b0;

      if (w_next != r_state)                            r_cyc <= '0;
      else if (r_state == S_SETTLE || r_state == S_MEAS) r_cyc <= r_cyc + 1'b1;

      // counter only accumulates in MEASURE, so each window starts from 0
      if (r_state == S_MEAS) r_cnt <= w_cnt_fin;
      else                   r_cnt <= '0;

      if (bus.stop) begin
        r_locked <= 1'b0;
      end else if (w_accept) begin
        r_tgt    <= bus.target;
        r_code   <= {1'b1, {(CODE_W-1){1'b0}}};
        r_idx    <= IDX_W'(CODE_W - 1);
        r_track  <= 1'b0;
        r_err    <= 1'b0;
        r_locked <= 1'b0;
        r_lcnt   <= '0;
      end else if (w_win_done) begin
        r_meas <= w_cnt_fin;
        r_mv   <= 1'b1;
        if (!r_track) begin
          r_code <= w_sar_code;
          if (r_idx != '0) r_idx   <= r_idx - 1'b1;
          else             r_track <= 1'b1;
        end else if (w_over) begin
          if (r_code != '0) r_code <= r_code - 1'b1;
          else              r_err  <= 1'b1;
          r_lcnt   <= '0;
          r_locked <= 1'b0;
        end else if (w_under) begin
          if (r_code != '1) r_code <= r_code + 1'b1;
          else              r_err  <= 1'b1;
          r_lcnt   <= '0;
          r_locked <= 1'b0;
        end else begin
          if (r_lcnt != LC_W'(LOCK_N))       r_lcnt   <= r_lcnt + 1'b1;
          if (r_lcnt >= LC_W'(LOCK_N - 1))   r_locked <= 1'b1;
        end
      end
    end
  end

  assign bus.busy       = (r_state != S_IDLE);
  assign bus.ring_en    = (r_state != S_IDLE);
  assign bus.code       = r_code;
  assign bus.meas       = r_meas;
  assign bus.meas_valid = r_mv;
  assign bus.locked     = r_locked;
  assign bus.err        = r_err;
endmodule

// File: tb/tb_ring_cal_ctrl.sv
module tb_ring_cal_ctrl;
  localparam int WINLEN = 265;  // SETTLE + WIN + 1

  logic Clk, Rst_n;
  int   n_err = 0, n_chk = 0;

  ring_cal_ctrl_if #(.CODE_W(6), .CNT_W(12)) bi ();
  ring_cal_ctrl_if #(.CODE_W(6), .CNT_W(8))  bi8 ();

  ring_cal_ctrl #(.CODE_W(6), .CNT_W(12)) u_dut (.Clk(Clk), .Rst_n(Rst_n), .bus(bi));
  ring_cal_ctrl #(.CODE_W(6), .CNT_W(8))  u_dut8 (.Clk(Clk), .Rst_n(Rst_n), .bus(bi8));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Behavioural reference: one call per completed window
  int m_tgt, m_code, m_bit, m_lcnt, m_meas;
  bit m_track, m_locked, m_err;

  task automatic model_start(input int tgt);
    m_tgt = tgt; m_code = 32; m_bit = 5; m_track = 0;
    m_lcnt = 0; m_locked = 0; m_err = 0;
  endtask

  task automatic model_window(input int ticks);
    m_meas = (ticks > 4095) ? 4095 : ticks;
    if (!m_track) begin
      if (m_meas > m_tgt) m_code -= (1 << m_bit);
      if (m_bit > 0) begin m_bit--; m_code += (1 << m_bit); end
      else m_track = 1;
    end else if (m_meas > m_tgt + 2) begin
      if (m_code > 0) m_code--; else m_err = 1;
      m_lcnt = 0; m_locked = 0;
    end else if (m_meas < m_tgt - 2) begin
      if (m_code < 63) m_code++; else m_err = 1;
      m_lcnt = 0; m_locked = 0;
    end else begin
      if (m_lcnt < 4) m_lcnt++;
      if (m_lcnt == 4) m_locked = 1;
    end
  endtask

  // One full window: exactly k*code ticks scattered over the measure slots,
  // noise ticks in settle/update slots that must not be counted.
  task automatic run_window(input int k, input bit force_last);
    bit sel[256];
    int n, j;
    bit t;
    n = k * m_code;
    if (n > 256) n = 256;
    for (int i = 0; i < 256; i++) sel[i] = (i < n);
    for (int i = 255; i > 0; i--) begin
      j = $urandom_range(i, 0);
      t = sel[i]; sel[i] = sel[j]; sel[j] = t;
    end
    if (force_last && n > 0 && !sel[255]) begin
      for (int i = 0; i < 255; i++) if (sel[i]) begin sel[i] = 0; sel[255] = 1; break; end
    end
    for (int o = 1; o <= WINLEN; o++) begin
      @(posedge Clk); #1;
      bi.start  = (o == 100);  // start while busy: ignored
      bi.target = 12'($urandom_range(4095, 0));
      if (o >= 9 && o <= 264)      bi.ring_tick = sel[o-9];
      else if (o == 8 || o == 265) bi.ring_tick = 1'b1;
      else                         bi.ring_tick = 1'($urandom_range(1, 0));
      if (o == 1) begin
        chk("code_at_settle", bi.code, m_code);
        chk("mv_low", bi.meas_valid, 0);
        chk("busy", bi.busy, 1);
      end
      if (o == WINLEN) begin
        model_window(n);
        chk("mv_update", bi.meas_valid, 1);
        chk("meas", bi.meas, m_meas);
        chk("code", bi.code, m_code);
        chk("locked", bi.locked, m_locked);
        chk("err", bi.err, m_err);
      end
    end
  endtask

  task automatic do_start(input int tgt);
    @(posedge Clk); #1;
    bi.start = 1'b1; bi.target = 12'(tgt);
    model_start(tgt);
  endtask

  task automatic do_stop();
    @(posedge Clk); #1; bi.stop = 1'b1; bi.start = 1'b0;
    @(posedge Clk); #1; bi.stop = 1'b0;
    m_locked = 0;
    chk("stop_busy", bi.busy, 0);
    chk("stop_ring_en", bi.ring_en, 0);
    chk("stop_locked", bi.locked, 0);
    chk("stop_code_hold", bi.code, m_code);
  endtask

  task automatic cyc(input bit tk);
    @(posedge Clk); #1; bi.ring_tick = tk; bi.start = 1'b0;
  endtask

  initial begin
    bit seen;
    int tg, k;
    Rst_n = 1'b0;
    bi.start = 0; bi.stop = 0; bi.target = '0; bi.ring_tick = 0;
    bi8.start = 0; bi8.stop = 0; bi8.target = '0; bi8.ring_tick = 1'b1;
    model_start(0); m_code = 0;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_busy", bi.busy, 0);
    chk("rst_code", bi.code, 0);
    chk("rst_meas", bi.meas, 0);
    chk("rst_locked", bi.locked, 0);
    Rst_n = 1'b1;

    // SAR convergence, 4 ticks per code step, target 100
    do_start(100);
    for (int w = 1; w <= 10; w++) begin
      run_window(4, w[0]);
      if (w == 6) begin
        chk("sar_final_code", bi.code, 25);
        chk("sar_final_meas", bi.meas, 100);
      end
      if (w == 9) chk("not_locked_w9", bi.locked, 0);
    end
    chk("locked_w10", bi.locked, 1);

    // Tracking: ring gets faster, code walks down to 20 then re-locks
    for (int w = 1; w <= 9; w++) begin
      run_window(5, w[0]);
      if (w == 1) chk("track_unlock", bi.locked, 0);
    end
    chk("track_code", bi.code, 20);
    chk("track_relock", bi.locked, 1);
    do_stop();
    chk("stop_meas_hold", bi.meas, 100);

    // Saturation error: unreachable target
    do_start(4095);
    for (int w = 1; w <= 8; w++) run_window(4, 1'b0);
    chk("sat_code", bi.code, 63);
    chk("sat_err", bi.err, 1);
    chk("sat_locked", bi.locked, 0);
    do_stop();

    // Random targets and slopes
    for (int r = 0; r < 3; r++) begin
      tg = $urandom_range(240, 20);
      k  = $urandom_range(4, 3);
      do_start(tg);
      for (int w = 1; w <= 8; w++) run_window(k, w[0]);
      do_stop();
    end

    // Abort mid-MEASURE with simultaneous start
    do_start(100);
    for (int o = 1; o <= 100; o++) cyc(1'($urandom_range(1, 0)));
    @(posedge Clk); #1; bi.stop = 1'b1; bi.start = 1'b1;
    @(posedge Clk); #1; bi.stop = 1'b0; bi.start = 1'b0;
    chk("abort_busy", bi.busy, 0);
    chk("abort_ring_en", bi.ring_en, 0);
    chk("abort_code", bi.code, 32);
    chk("abort_locked", bi.locked, 0);
    seen = 0;
    for (int o = 0; o < 300; o++) begin
      cyc(1'($urandom_range(1, 0)));
      if (bi.meas_valid || bi.busy) seen = 1;
    end
    chk("abort_quiet", seen, 0);

    // Async reset mid-MEASURE
    do_start(100);
    for (int o = 1; o <= 50; o++) cyc(1'b1);
    #2 Rst_n = 1'b0;
    #1;
    chk("arst_ring_en", bi.ring_en, 0);
    chk("arst_busy", bi.busy, 0);
    chk("arst_code", bi.code, 0);
    chk("arst_meas", bi.meas, 0);
    chk("arst_mv", bi.meas_valid, 0);
    chk("arst_locked", bi.locked, 0);
    chk("arst_err", bi.err, 0);
    @(negedge Clk); Rst_n = 1'b1;
    seen = 0;
    for (int o = 0; o < 300; o++) begin
      cyc(1'b1);
      if (bi.busy || bi.meas_valid || bi.code != 0 || bi.meas != 0) seen = 1;
    end
    chk("arst_idle_after", seen, 0);

    // 8-bit counter saturation with ring_tick stuck high
    @(posedge Clk); #1; bi8.start = 1'b1;
    @(posedge Clk); #1; bi8.start = 1'b0;
    repeat (WINLEN - 1) @(posedge Clk);
    #1;
    chk("cnt8_mv", bi8.meas_valid, 1);
    chk("cnt8_meas", bi8.meas, 255);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
